// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/multu/div/divu unit with HI/LO registers and stall logic
// Multiply is radix-2 shift-add and divide is restoring; both share one accumulator pair.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       mul_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic             r_is_mul;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_mul_next;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_accept = (r_state == S_IDLE) && issue_valid && $onehot(mul_control);
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_signed = mul_control[0] | mul_control[2];
  assign w_sa     = w_signed & op_a[WIDTH-1];
  assign w_sb     = w_signed & op_b[WIDTH-1];
  assign w_a_mag  = w_sa ? -op_a : op_a;
  assign w_b_mag  = w_sb ? -op_b : op_b;

  // Multiply step: conditionally add multiplicand to the upper half, then shift the pair right.
  assign w_add      = {1'b0, r_acc_hi} + {1'b0, r_b_mag};
  assign w_mul_next = r_acc_lo[0] ? w_add : {1'b0, r_acc_hi};

  // Divide step: shift remainder left taking the next dividend bit; a clear borrow means it fits.
  assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b_mag};
  assign w_ge    = ~w_diff[WIDTH];

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_is_mul) begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_div0) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else begin
      w_res_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
      w_res_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_CALC;
      S_CALC: begin
        if (cancel)      w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_SIGN;
      end
      S_SIGN:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_SIGN);
    issue_ready = (r_state == S_IDLE);
    stall       = (r_state != S_IDLE) & (issue_valid | rd_hi | rd_lo | wr_hi | wr_lo);
    rd_data     = rd_hi ? r_hi : r_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a_raw  <= '0;
      r_b_mag  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_is_mul <= mul_control[0] | mul_control[1];
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_div0   <= (mul_control[2] | mul_control[3]) && (op_b == '0);
      r_a_raw  <= op_a;
      r_b_mag  <= w_b_mag;
      r_acc_hi <= '0;
      r_acc_lo <= w_a_mag;
    end else if (r_state == S_CALC) begin
      r_count <= r_count + CW'(1);
      if (r_is_mul) begin
        r_acc_hi <= w_mul_next[WIDTH:1];
        r_acc_lo <= {w_mul_next[0], r_acc_lo[WIDTH-1:1]};
      end else begin
        r_acc_hi <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
      end
    end
  end

  // mthi/mtlo only land while idle; while busy they stall and are re-presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_SIGN) begin
      if (!cancel) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if (r_state == S_IDLE) begin
      if (wr_hi) r_hi <= wdata;
      if (wr_lo) r_lo <= wdata;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  mul_control = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cancel = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .mul_control(mul_control), .op_a(op_a), .op_b(op_b), .cancel(cancel),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle, then steps until busy drops (cycle 34 when on time).
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cnt);
    issue_valid = 1'b1; mul_control = ctrl; op_a = a; op_b = b;
    tick();
    issue_valid = 1'b0; mul_control = 4'b0;
    done_cyc = -1; busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({busy, done, stall, issue_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0001", {busy, done, stall, issue_ready});
    end
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int dc, bc;
    run_op(4'b0001, 32'hFFFFFFFE, 32'h3, dc, bc);
    n_tests++;
    if (dc !== 33) begin n_fail++; $display("FAIL mult_done_cycle: got %0d expected 33", dc); end
    n_tests++;
    if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
    n_tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_result: got %h/%h expected ffffffff/fffffffa", hi, lo);
    end
  endtask

  task automatic test_multu();
    int dc, bc;
    run_op(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, bc);
    n_tests++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu_result: got %h/%h expected fffffffe/00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int dc, bc;
    run_op(4'b0100, 32'hFFFFFFF9, 32'h2, dc, bc);
    n_tests++;
    if (dc !== 33) begin n_fail++; $display("FAIL div_done_cycle: got %0d expected 33", dc); end
    n_tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_result: got %h/%h expected ffffffff/fffffffd", hi, lo);
    end
    run_op(4'b1000, 32'h7, 32'h0, dc, bc);
    n_tests++;
    if (hi !== 32'h00000007 || lo !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL divu_by_zero: got %h/%h expected 00000007/ffffffff", hi, lo);
    end
  endtask

  task automatic test_overflow_mthi();
    int dc, bc;
    run_op(4'b0100, 32'h80000000, 32'hFFFFFFFF, dc, bc);
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      n_fail++; $display("FAIL div_overflow: got %h/%h expected 00000000/80000000", hi, lo);
    end
    wr_hi = 1'b1; wdata = 32'h1234; rd_hi = 1'b1;
    #1;
    n_tests++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL mthi_mfhi_same_cycle: got %h expected 00000000", rd_data);
    end
    tick();
    wr_hi = 1'b0;
    #1;
    n_tests++;
    if (hi !== 32'h1234 || rd_data !== 32'h1234) begin
      n_fail++; $display("FAIL mthi_readback: got hi=%h rd=%h expected 00001234", hi, rd_data);
    end
    rd_hi = 1'b0;
    rd_lo = 1'b1;
    #1;
    n_tests++;
    if (rd_data !== 32'h80000000) begin
      n_fail++; $display("FAIL mflo_readback: got %h expected 80000000", rd_data);
    end
    rd_lo = 1'b0;
    tick();
  endtask

  task automatic test_stall_back_to_back();
    int stall_bad;
    int cyc;
    stall_bad = 0;
    issue_valid = 1'b1; mul_control = 4'b0100; op_a = 32'd100; op_b = 32'd7;
    tick();
    issue_valid = 1'b0; mul_control = 4'b0;
    tick(); tick(); tick(); tick();
    rd_hi = 1'b1;
    issue_valid = 1'b1; mul_control = 4'b0010; op_a = 32'd3; op_b = 32'd5;
    cyc = 5;
    while (cyc <= 33) begin
      #1;
      if (stall !== 1'b1) stall_bad++;
      tick();
      cyc++;
    end
    #1;
    n_tests++;
    if (stall_bad !== 0) begin
      n_fail++; $display("FAIL stall_while_busy: got %0d low cycles expected 0", stall_bad);
    end
    n_tests++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_release_c34: got stall=%b busy=%b expected 0/0", stall, busy);
    end
    n_tests++;
    if (rd_data !== 32'd2) begin
      n_fail++; $display("FAIL mfhi_after_div: got %h expected 00000002", rd_data);
    end
    tick();
    rd_hi = 1'b0; issue_valid = 1'b0; mul_control = 4'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reissue_accept: got busy=%b expected 1", busy); end
    for (int c = 0; c < 40 && busy; c++) tick();
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'd15) begin
      n_fail++; $display("FAIL reissue_result: got %h/%h expected 00000000/0000000f", hi, lo);
    end
  endtask

  task automatic test_invalid_ctrl();
    issue_valid = 1'b1; mul_control = 4'b0011; op_a = 32'd9; op_b = 32'd9;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL multihot_ignored: got busy=%b expected 0", busy); end
    mul_control = 4'b0000;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zerohot_ignored: got busy=%b expected 0", busy); end
    issue_valid = 1'b0;
  endtask

  task automatic test_accept_with_mthi();
    int dc, bc;
    wr_hi = 1'b1; wdata = 32'h77;
    issue_valid = 1'b1; mul_control = 4'b0010; op_a = 32'd2; op_b = 32'd3;
    tick();
    wr_hi = 1'b0; issue_valid = 1'b0; mul_control = 4'b0;
    n_tests++;
    if (hi !== 32'h77 || busy !== 1'b1) begin
      n_fail++; $display("FAIL accept_mthi_write: got hi=%h busy=%b expected 00000077/1", hi, busy);
    end
    for (int c = 0; c < 40 && busy; c++) tick();
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      n_fail++; $display("FAIL accept_mthi_result: got %h/%h expected 00000000/00000006", hi, lo);
    end
  endtask

  task automatic test_cancel();
    int saw_done;
    saw_done = 0;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    n_tests++;
    if (hi !== 32'hA5A5 || lo !== 32'hA5A5) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got %h/%h expected 0000a5a5/0000a5a5", hi, lo);
    end
    issue_valid = 1'b1; mul_control = 4'b0001; op_a = 32'd5; op_b = 32'd7;
    tick();
    issue_valid = 1'b0; mul_control = 4'b0;
    for (int c = 1; c < 10; c++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    for (int c = 0; c < 30; c++) begin
      if (done) saw_done++;
      tick();
    end
    n_tests++;
    if (hi !== 32'hA5A5 || lo !== 32'hA5A5 || saw_done !== 0) begin
      n_fail++; $display("FAIL cancel_no_write: got %h/%h done=%0d expected 0000a5a5/0000a5a5/0", hi, lo, saw_done);
    end
  endtask

  task automatic test_reset_mid();
    int saw_done;
    saw_done = 0;
    issue_valid = 1'b1; mul_control = 4'b0011 ^ 4'b0010; op_a = 32'd5; op_b = 32'd7;
    tick();
    issue_valid = 1'b0; mul_control = 4'b0;
    for (int c = 1; c < 12; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_calc: got busy=%b %h/%h expected 0 00000000/00000000", busy, hi, lo);
    end
    for (int c = 0; c < 30; c++) begin
      if (done) saw_done++;
      tick();
    end
    n_tests++;
    if (saw_done !== 0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got done=%0d lo=%h expected 0/00000000", saw_done, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_overflow_mthi();
    test_stall_back_to_back();
    test_invalid_ctrl();
    test_accept_with_mthi();
    test_cancel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
